cp0_irq_timer: RTL and testbench
================================

Name: cp0_irq_timer

Overview:
Parametrised coprocessor-0 successor for the single-cycle/multicycle MIPS datapath. It replaces the single TimerInterrupt input with NUM_IRQ external, level-sensitive, individually maskable interrupt lines, plus an internal Count/Compare timer on IP7. It also reports the highest-priority pending source. It sits beside the register file: it is read and written via MTC0/MFC0 and supplies EPC and TakenInterrupt to the PC-select logic.

Parameters:
NUM_IRQ, 6, number of external interrupt lines (1..7); line i maps to Cause/Status bit 8+i.
PC_WIDTH, 30, word-address width of next_pc and EPC.
COUNT_DIV, 2, number of clock cycles per Count increment (>=1).

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
rd_data  out  32  combinational read of register regnum
EPC  out  PC_WIDTH  exception PC (word address)
TakenInterrupt  out  1  combinational; redirect PC to handler this cycle
irq_id  out  3  index of highest-priority pending enabled source (7 = timer); 0 when none
wr_data  in  32  MTC0 write data
regnum  in  5  CP0 register select
next_pc  in  PC_WIDTH  PC saved on interrupt
MTC0  in  1  write enable for regnum
ERET  in  1  exception return
irq  in  NUM_IRQ  external interrupt request lines, level-sensitive

Behaviour:
- Registers: Count=9, Compare=11, Status=12, Cause=13, EPC=14. All other regnum values read 0, and writes to them are ignored.
- Reset values: Count=0, Compare=32'hFFFF_FFFF, Status IM=0, IE=0, EXL=0, IP7=0, EPC=0, prescaler=0.
- Status read = {16'b0, IM[7:0], 6'b0, EXL, IE}.
  - MTC0 Status writes IM[7:0]=wr_data[15:8] and IE=wr_data[0].
  - IM bits for unimplemented lines (8+NUM_IRQ..14) are forced to 0.
  - EXL is not software-writable.
- Cause read = {16'b0, IP[7:0], 8'b0}.
  - IP[i]=irq[i] live for i<NUM_IRQ. Unused IP bits read 0. IP7 = sticky timer flag.
  - Cause is read-only; MTC0 to Cause is ignored.
- EPC read = {EPC, 2'b0}. MTC0 EPC loads wr_data[PC_WIDTH+1:2].
- Timer:
  - The prescaler counts 0..COUNT_DIV-1 and wraps. Count increments by 1 on the cycle the prescaler wraps.
  - Count wraps from 32'hFFFF_FFFF to 0 silently.
  - MTC0 Count loads wr_data and resets the prescaler; that cycle's increment is suppressed.
  - IP7 is set on any cycle where Count==Compare, regardless of the prescaler.
  - MTC0 Compare loads wr_data and clears IP7. Clear wins over a same-cycle match.
  - IP7 otherwise holds until cleared.
- pending = IP & IM.
- TakenInterrupt = (|pending) & IE & ~EXL.
- irq_id = highest set index of pending (timer 7 highest, then NUM_IRQ-1 down to 0). It is valid regardless of IE/EXL.
- On TakenInterrupt at a rising edge:
  - EPC <= next_pc, overriding a same-cycle MTC0 EPC.
  - EXL <= 1.
- Exception level:
  - ERET clears EXL on the next edge.
  - ERET with TakenInterrupt in the same cycle: set wins, EXL=1.
  - With EXL=1 no further interrupts are taken (no nesting). Pending requests stay visible in Cause and are taken one cycle after ERET clears EXL.
- Reset mid-operation clears everything to reset values, including IP7; irq lines remain live.

Test Plan:
- Reset, then read regs 9/11/12/13/14 -> 0, FFFF_FFFF, 0, {IP live}, 0; TakenInterrupt=0, irq_id=0.
- MTC0 Status=32'h0000_0401, raise irq[2], next_pc=30'h100 -> TakenInterrupt=1 same cycle, irq_id=2; next cycle EPC=30'h100, Status reads 32'h0000_0403, TakenInterrupt=0.
- Timer, COUNT_DIV=2: MTC0 Count=0, Compare=5, Status=32'h8001 -> Count reaches 5 after 10 cycles, IP7 set, irq_id=7, interrupt taken; MTC0 Compare=20 -> Cause bit15 clears.
- irq[0] and irq[4] high, IM bits 8 and 12 set -> irq_id=4. Mask bit 12 -> irq_id=0.
- Taken interrupt with EXL=1 held and irq still asserted -> no retake; ERET -> EXL=0, retaken next cycle, EPC updated again.
- Same cycle MTC0 EPC=32'h40 and TakenInterrupt with next_pc=30'h55 -> EPC=30'h55.
- Count=32'hFFFF_FFFF wraps to 0 with no IP7 (Compare=7); assert reset during a pending IP7 -> IP7=0.

Source files
------------

// File: rtl/cp0_irq_timer.sv
// CP0 for the MIPS datapath: NUM_IRQ maskable level interrupts plus a Count/Compare timer on IP7.
// Register reads and TakenInterrupt are combinational; all state updates on the rising clock edge.
module cp0_irq_timer #(
  parameter int NUM_IRQ   = 6,
  parameter int PC_WIDTH  = 30,
  parameter int COUNT_DIV = 2
) (
  input  logic                clock,
  input  logic                reset,
  output logic [31:0]         rd_data,
  output logic [PC_WIDTH-1:0] EPC,
  output logic                TakenInterrupt,
  output logic [2:0]          irq_id,
  input  logic [31:0]         wr_data,
  input  logic [4:0]          regnum,
  input  logic [PC_WIDTH-1:0] next_pc,
  input  logic                MTC0,
  input  logic                ERET,
  input  logic [NUM_IRQ-1:0]  irq
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  // Timer mask bit is always implemented; external lines only up to NUM_IRQ.
  localparam logic [7:0] IM_MASK = 8'h80 | 8'((1 << NUM_IRQ) - 1);

  logic [31:0]         r_count;
  logic [31:0]         r_compare;
  logic [PW-1:0]       r_presc;
  logic [7:0]          r_im;
  logic                r_ie;
  logic                r_exl;
  logic                r_ip7;
  logic [PC_WIDTH-1:0] r_epc;

  logic       w_wr_count;
  logic       w_wr_compare;
  logic       w_wr_status;
  logic       w_wr_epc;
  logic       w_presc_wrap;
  logic [7:0] w_ip;
  logic [7:0] w_pending;

  assign w_wr_count   = MTC0 && (regnum == 5'd9);
  assign w_wr_compare = MTC0 && (regnum == 5'd11);
  assign w_wr_status  = MTC0 && (regnum == 5'd12);
  assign w_wr_epc     = MTC0 && (regnum == 5'd14);
  assign w_presc_wrap = (r_presc == PW'(COUNT_DIV - 1));

  always_comb begin
    w_ip = '0;
    for (int i = 0; i < NUM_IRQ; i++) w_ip[i] = irq[i];
    w_ip[7] = r_ip7;
  end

  assign w_pending      = w_ip & r_im;
  assign TakenInterrupt = (|w_pending) & r_ie & ~r_exl;
  assign EPC            = r_epc;

  always_comb begin
    irq_id = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_pending[i]) irq_id = 3'(i);
    end
  end

  // A Count write restarts the prescaler and replaces this cycle's increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_presc <= '0;
    end else if (w_wr_count) begin
      r_count <= wr_data;
      r_presc <= '0;
    end else if (w_presc_wrap) begin
      r_count <= r_count + 32'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // The match compares registered Count, so a Compare write clearing IP7 wins over it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_compare <= 32'hFFFF_FFFF;
      r_ip7     <= 1'b0;
    end else if (w_wr_compare) begin
      r_compare <= wr_data;
      r_ip7     <= 1'b0;
    end else if (r_count == r_compare) begin
      r_ip7 <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_im <= '0;
      r_ie <= 1'b0;
    end else if (w_wr_status) begin
      r_im <= wr_data[15:8] & IM_MASK;
      r_ie <= wr_data[0];
    end
  end

  // Interrupt entry takes precedence over both software EPC writes and ERET.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_epc <= '0;
      r_exl <= 1'b0;
    end else if (TakenInterrupt) begin
      r_epc <= next_pc;
      r_exl <= 1'b1;
    end else begin
      if (w_wr_epc) r_epc <= wr_data[PC_WIDTH+1:2];
      if (ERET)     r_exl <= 1'b0;
    end
  end

  always_comb begin
    case (regnum)
      5'd9:    rd_data = r_count;
      5'd11:   rd_data = r_compare;
      5'd12:   rd_data = {16'b0, r_im, 6'b0, r_exl, r_ie};
      5'd13:   rd_data = {16'b0, w_ip, 8'b0};
      5'd14:   rd_data = 32'({r_epc, 2'b00});
      default: rd_data = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_timer.sv
// Scoreboard bench for cp0_irq_timer: expected values queued with stimulus, popped at sample time.
module tb_cp0_irq_timer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rd_data;
  logic [29:0] EPC;
  logic        TakenInterrupt;
  logic [2:0]  irq_id;
  logic [31:0] wr_data = '0;
  logic [4:0]  regnum = '0;
  logic [29:0] next_pc = '0;
  logic        MTC0 = 1'b0;
  logic        ERET = 1'b0;
  logic [5:0]  irq = '0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  logic [31:0] obs;

  cp0_irq_timer #(.NUM_IRQ(6), .PC_WIDTH(30), .COUNT_DIV(2)) dut (
    .clock(clock), .reset(reset), .rd_data(rd_data), .EPC(EPC),
    .TakenInterrupt(TakenInterrupt), .irq_id(irq_id), .wr_data(wr_data),
    .regnum(regnum), .next_pc(next_pc), .MTC0(MTC0), .ERET(ERET), .irq(irq)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; MTC0 = 1'b0; ERET = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] r, input logic [31:0] d);
    MTC0 = 1'b1; regnum = r; wr_data = d;
    tick();
    MTC0 = 1'b0; wr_data = '0;
  endtask

  task automatic rd(input logic [4:0] r, output logic [31:0] d);
    regnum = r;
    #1;
    d = rd_data;
  endtask

  task automatic test_reset();
    irq = 6'b000101;
    do_reset();
    exp_q.push_back(32'h0); exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0);
    exp_q.push_back(32'h0000_0500); exp_q.push_back(32'h0);
    foreach (exp_q[k]) begin end
    begin
      logic [4:0] regs [5] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14};
      for (int i = 0; i < 5; i++) begin
        rd(regs[i], obs);
        exp_v = exp_q.pop_front(); n_vec++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL reset_reg%0d: got %h expected %h", regs[i], obs, exp_v);
        end
      end
    end
    exp_q.push_back({29'd0, 3'd0});
    obs = {28'd0, TakenInterrupt, irq_id}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_taken_id: got %h expected %h", obs, exp_v); end
    // Cause is read-only and unmapped registers read zero.
    mtc0(5'd13, 32'hFFFF_FFFF);
    mtc0(5'd5, 32'h1234_5678);
    exp_q.push_back(32'h0000_0500);
    rd(5'd13, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL cause_ro: got %h expected %h", obs, exp_v); end
    exp_q.push_back(32'h0);
    rd(5'd5, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL unmapped_rd: got %h expected %h", obs, exp_v); end
    irq = '0;
  endtask

  task automatic test_status_mask();
    do_reset();
    mtc0(5'd12, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_BF01);
    rd(5'd12, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL status_im_mask: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_ext_irq();
    do_reset();
    mtc0(5'd12, 32'h0000_0401);
    irq = 6'b000100; next_pc = 30'h100;
    exp_q.push_back(32'h0000_000A);
    #1; obs = {28'd0, TakenInterrupt, irq_id}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL ext_taken_id: got %h expected %h", obs, exp_v); end
    tick();
    exp_q.push_back(32'h100);
    obs = 32'(EPC); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL ext_epc: got %h expected %h", obs, exp_v); end
    exp_q.push_back(32'h0000_0403);
    rd(5'd12, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL ext_status: got %h expected %h", obs, exp_v); end
    exp_q.push_back(32'h0);
    obs = {31'd0, TakenInterrupt}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL ext_no_retake: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_no_nesting();
    // continues from test_ext_irq: EXL=1, irq[2] still high
    next_pc = 30'h200;
    tick(); tick(); tick();
    exp_q.push_back(32'h100);
    obs = {TakenInterrupt, 1'b0, EPC}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL exl_hold: got %h expected %h", obs, exp_v); end
    ERET = 1'b1;
    tick();
    ERET = 1'b0; next_pc = 30'h300;
    exp_q.push_back(32'h1);
    #1; obs = {31'd0, TakenInterrupt}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL eret_retake: got %h expected %h", obs, exp_v); end
    // ERET in the same cycle as a taken interrupt: EXL stays set.
    ERET = 1'b1;
    tick();
    ERET = 1'b0;
    exp_q.push_back(32'h300);
    obs = 32'(EPC); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL retake_epc: got %h expected %h", obs, exp_v); end
    exp_q.push_back(32'h0000_0403);
    rd(5'd12, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL eret_vs_take: got %h expected %h", obs, exp_v); end
    irq = '0;
  endtask

  task automatic test_priority();
    do_reset();
    irq = 6'b010001;
    mtc0(5'd12, 32'h0000_1100);
    exp_q.push_back(32'h4);
    #1; obs = {28'd0, TakenInterrupt, irq_id}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL prio_4: got %h expected %h", obs, exp_v); end
    mtc0(5'd12, 32'h0000_0100);
    exp_q.push_back(32'h0);
    #1; obs = {28'd0, TakenInterrupt, irq_id}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL prio_masked: got %h expected %h", obs, exp_v); end
    irq = '0;
  endtask

  task automatic test_epc_override();
    do_reset();
    mtc0(5'd14, 32'h0000_0040);
    exp_q.push_back(32'h10);
    obs = 32'(EPC); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL epc_write: got %h expected %h", obs, exp_v); end
    mtc0(5'd12, 32'h0000_0401);
    irq = 6'b000100; next_pc = 30'h55;
    mtc0(5'd14, 32'h0000_0040);
    exp_q.push_back(32'h55);
    obs = 32'(EPC); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL epc_override: got %h expected %h", obs, exp_v); end
    irq = '0;
  endtask

  task automatic test_timer();
    do_reset();
    mtc0(5'd9, 32'd0);
    mtc0(5'd11, 32'd5);
    mtc0(5'd12, 32'h0000_8001);
    repeat (8) tick();
    exp_q.push_back(32'd5); exp_q.push_back(32'h0);
    rd(5'd9, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timer_count5: got %h expected %h", obs, exp_v); end
    rd(5'd13, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timer_ip7_early: got %h expected %h", obs, exp_v); end
    tick();
    exp_q.push_back(32'h0000_8000); exp_q.push_back(32'hF);
    rd(5'd13, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timer_ip7_set: got %h expected %h", obs, exp_v); end
    obs = {28'd0, TakenInterrupt, irq_id}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timer_taken_id: got %h expected %h", obs, exp_v); end
    tick();
    mtc0(5'd11, 32'd20);
    exp_q.push_back(32'h0);
    rd(5'd13, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL timer_ip7_clear: got %h expected %h", obs, exp_v); end
  endtask

  task automatic test_wrap_reset();
    bit seen;
    do_reset();
    mtc0(5'd11, 32'd7);
    mtc0(5'd9, 32'hFFFF_FFFF);
    exp_q.push_back(32'hFFFF_FFFF);
    rd(5'd9, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL wrap_load: got %h expected %h", obs, exp_v); end
    tick(); tick();
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(5'd9, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL wrap_zero: got %h expected %h", obs, exp_v); end
    rd(5'd13, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL wrap_no_ip7: got %h expected %h", obs, exp_v); end
    seen = 1'b0;
    regnum = 5'd13;
    for (int c = 0; c < 40 && !seen; c++) begin
      tick();
      if (rd_data[15]) seen = 1'b1;
    end
    exp_q.push_back(32'h1);
    obs = {31'd0, seen}; exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL wrap_ip7_timeout: got %h expected %h", obs, exp_v); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.push_back(32'h0); exp_q.push_back(32'h0);
    rd(5'd13, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_ip7: got %h expected %h", obs, exp_v); end
    rd(5'd9, obs); exp_v = exp_q.pop_front(); n_vec++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_count: got %h expected %h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_status_mask();
    test_ext_irq();
    test_no_nesting();
    test_priority();
    test_epc_override();
    test_timer();
    test_wrap_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
